// File: rtl/alu_ctrl_pkg.sv
// Shared constants and FSM state type for the pipelined ALU control decoder.
// Optional M-extension decode is enabled by defining ALUCTL_MEXT_EN.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_MULH = 4'b1011;
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_REM  = 4'b1110;
    localparam logic [3:0] ALU_REMU = 4'b1111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7 decode table; illegal encodings yield ADD.
// M-extension rows are present only when ALUCTL_MEXT_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] code_o,
    output logic       illegal_o,
    output logic       multicycle_o
);

    always_comb begin
        code_o       = ALU_ADD;
        illegal_o    = 1'b0;
        multicycle_o = 1'b0;
        case (aluop_i)
            ALUOP_MEM: code_o = ALU_ADD;
            ALUOP_BR: begin
                case (funct3_i)
                    3'b000, 3'b001: code_o = ALU_SUB;
                    3'b100, 3'b101: code_o = ALU_SLT;
                    3'b110, 3'b111: code_o = ALU_SLTU;
                    default:        illegal_o = 1'b1;
                endcase
            end
            ALUOP_R: begin
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        3'b000:  code_o = ALU_ADD;
                        3'b001:  code_o = ALU_SLL;
                        3'b010:  code_o = ALU_SLT;
                        3'b011:  code_o = ALU_SLTU;
                        3'b100:  code_o = ALU_XOR;
                        3'b101:  code_o = ALU_SRL;
                        3'b110:  code_o = ALU_OR;
                        default: code_o = ALU_AND;
                    endcase
                end else if (funct7_i == F7_ALT) begin
                    case (funct3_i)
                        3'b000:  code_o = ALU_SUB;
                        3'b101:  code_o = ALU_SRA;
                        default: illegal_o = 1'b1;
                    endcase
`ifdef ALUCTL_MEXT_EN
                end else if (funct7_i == F7_MEXT) begin
                    multicycle_o = 1'b1;
                    case (funct3_i)
                        3'b000:  code_o = ALU_MUL;
                        3'b100:  code_o = ALU_DIV;
                        3'b101:  code_o = ALU_DIVU;
                        3'b110:  code_o = ALU_REM;
                        3'b111:  code_o = ALU_REMU;
                        default: code_o = ALU_MULH;
                    endcase
`endif
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered, valid/ready ALU control decoder with multi-cycle issue stall.
// Define ALUCTL_MEXT_EN to decode M ops and build the WAIT state/counter.
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic              out_illegal,
    output logic              out_multicycle,
    output logic              busy
);

    logic [3:0]        dec_code;
    logic              dec_ill;
    logic              dec_mc;
    logic              accept;
    logic              issue_mc;
    state_e            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              ill_q, ill_d;

    alu_ctrl_decode u_decode (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .funct7_i     (funct7),
        .code_o       (dec_code),
        .illegal_o    (dec_ill),
        .multicycle_o (dec_mc)
    );

    assign accept = in_valid && in_ready;

`ifdef ALUCTL_MEXT_EN
    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, lat_m1;
    logic             mc_q, mc_d;

    assign issue_mc = dec_mc;

    always_comb begin
        lat_m1 = CNT_W'(DIV_LAT - 1);
        if (dec_code == ALU_MUL || dec_code == ALU_MULH) begin
            lat_m1 = CNT_W'(MUL_LAT - 1);
        end
    end

    // Countdown reloads on every acceptance; WAIT leaves when it reaches 1.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = issue_mc ? lat_m1 : '0;
        end else if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign mc_d = accept ? dec_mc : mc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            mc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mc_q  <= mc_d;
        end
    end

    assign out_multicycle = mc_q;
`else
    logic unused_cfg;

    assign issue_mc       = 1'b0;
    assign out_multicycle = 1'b0;
    assign unused_cfg     = ^{dec_mc, MUL_LAT, DIV_LAT};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = issue_mc ? ST_WAIT : ST_OUT;
            end
`ifdef ALUCTL_MEXT_EN
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_OUT;
            end
`endif
            ST_OUT: begin
                if (out_ready) begin
                    if (accept) state_d = issue_mc ? ST_WAIT : ST_OUT;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = !flush;
`ifdef ALUCTL_MEXT_EN
            ST_WAIT: busy = 1'b1;
`endif
            ST_OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !flush;
            end
            default: ;
        endcase
    end

    assign ctrl_d = accept ? CTRL_W'(dec_code) : ctrl_q;
    assign ill_d  = accept ? dec_ill : ill_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ill_q  <= ill_d;
        end
    end

    assign out_alu_ctrl = ctrl_q;
    assign out_illegal  = ill_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe: transaction-level model plus directed vectors.
// Expectations follow the ALUCTL_MEXT_EN setting the bench is compiled with.
module tb_alu_control_pipe;

    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        in_ready, out_valid, out_illegal, out_multicycle, busy;
    logic [CTRL_W-1:0] out_alu_ctrl;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    alu_control_pipe #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .aluop          (aluop),
        .funct3         (funct3),
        .funct7         (funct7),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_ctrl   (out_alu_ctrl),
        .out_illegal    (out_illegal),
        .out_multicycle (out_multicycle),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: returns {multicycle, illegal, code[3:0]}.
    function automatic logic [5:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        logic [3:0] r_tab [8];
        r_tab = '{4'h2, 4'h4, 4'h7, 4'h8, 4'h3, 4'h5, 4'h1, 4'h0};
        if (op == 2'd0) return {2'b00, 4'h2};
        if (op == 2'd1) begin
            if (f3[2:1] == 2'b01) return {2'b01, 4'h2};
            if (!f3[2])           return {2'b00, 4'h6};
            return {2'b00, f3[1] ? 4'h8 : 4'h7};
        end
        if (op == 2'd2) begin
            if (f7 == 7'h00) return {2'b00, r_tab[f3]};
            if (f7 == 7'h20) begin
                if (f3 == 3'd0) return {2'b00, 4'h6};
                if (f3 == 3'd5) return {2'b00, 4'h9};
                return {2'b01, 4'h2};
            end
`ifdef ALUCTL_MEXT_EN
            if (f7 == 7'h01) begin
                if (f3 == 3'd0) return {2'b10, 4'hA};
                if (f3 <= 3'd3) return {2'b10, 4'hB};
                return {2'b10, 4'(f3) + 4'd8};
            end
`endif
        end
        return {2'b01, 4'h2};
    endfunction

    // Model: one outstanding result, m_wait cycles before it becomes visible.
    bit         m_pend = 1'b0;
    int         m_wait = 0;
    logic [3:0] m_code = 4'h0;
    logic       m_ill = 1'b0;
    logic       m_mc = 1'b0;

    function automatic bit m_ready();
        return !flush && (!m_pend || (m_wait == 0 && out_ready));
    endfunction

    always @(posedge clock) begin
        logic [5:0] d;
        bit take;
        if (reset) begin
            m_pend = 1'b0; m_wait = 0; m_code = 4'h0; m_ill = 1'b0; m_mc = 1'b0;
        end else if (flush) begin
            m_pend = 1'b0; m_wait = 0;
        end else begin
            take = in_valid && m_ready();
            if (m_pend && m_wait > 0) m_wait--;
            else if (m_pend && out_ready) m_pend = 1'b0;
            if (take) begin
                d = ref_dec(aluop, funct3, funct7);
                m_code = d[3:0]; m_ill = d[4]; m_mc = d[5]; m_pend = 1'b1;
                m_wait = d[5] ? (((d[3:0] == 4'hA) || (d[3:0] == 4'hB)) ? MUL_LAT : DIV_LAT) - 1 : 0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_in_ready",  in_ready,       m_ready());
            chk("m_out_valid", out_valid,      m_pend && m_wait == 0);
            chk("m_busy",      busy,           m_pend && m_wait > 0);
            chk("m_alu_ctrl",  out_alu_ctrl,   m_code);
            chk("m_illegal",   out_illegal,    m_ill);
            chk("m_multicyc",  out_multicycle, m_mc);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        in_valid = v; aluop = op; funct3 = f3; funct7 = f7;
    endtask

    initial begin
        int  cyc;
        int  guard;
        bit  acc;
        logic [6:0] f7s [4];
        f7s = '{7'h00, 7'h20, 7'h01, 7'h7f};
        cyc = 0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        step;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ctrl", out_alu_ctrl, 4'h0);
        step;
        reset = 1'b0;

        // OR after reset
        drive(1'b1, 2'd2, 3'd6, 7'h00);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        @(negedge clock);
        chk("or_valid", out_valid, 1'b1);
        chk("or_code", out_alu_ctrl, 4'b0001);
        chk("or_ill", out_illegal, 1'b0);
        step;
        @(negedge clock);
        chk("or_idle", out_valid, 1'b0);

        // back-to-back ADD, SUB, SRA
        step;
        drive(1'b1, 2'd2, 3'd0, 7'h00);
        step;
        drive(1'b1, 2'd2, 3'd0, 7'h20);
        @(negedge clock);
        chk("b2b_add", out_alu_ctrl, 4'b0010);
        chk("b2b_rdy1", in_ready, 1'b1);
        step;
        drive(1'b1, 2'd2, 3'd5, 7'h20);
        @(negedge clock);
        chk("b2b_sub", out_alu_ctrl, 4'b0110);
        chk("b2b_rdy2", in_ready, 1'b1);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        @(negedge clock);
        chk("b2b_sra", out_alu_ctrl, 4'b1001);
        chk("b2b_val", out_valid, 1'b1);

        // SUB held under backpressure, next request taken when out_ready rises
        step;
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 3'd0, 7'h20);
        step;
        drive(1'b1, 2'd2, 3'd0, 7'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_code", out_alu_ctrl, 4'b0110);
            chk("hold_rdy", in_ready, 1'b0);
            step;
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("hold_release_rdy", in_ready, 1'b1);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        @(negedge clock);
        chk("hold_next_code", out_alu_ctrl, 4'b0010);
        step;

        // illegal encodings
        drive(1'b1, 2'd3, 3'd0, 7'h00);
        step;
        drive(1'b1, 2'd1, 3'd2, 7'h00);
        @(negedge clock);
        chk("ill_op3", out_illegal, 1'b1);
        chk("ill_op3_code", out_alu_ctrl, 4'b0010);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        @(negedge clock);
        chk("ill_br", out_illegal, 1'b1);
        chk("ill_br_code", out_alu_ctrl, 4'b0010);
        step;

        // MUL then DIVU latency
        drive(1'b1, 2'd2, 3'd0, 7'h01);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
`ifdef ALUCTL_MEXT_EN
        @(negedge clock);
        chk("mul_busy1", busy, 1'b1);
        step;
        @(negedge clock);
        chk("mul_busy2", busy, 1'b1);
        chk("mul_nval2", out_valid, 1'b0);
        step;
        @(negedge clock);
        chk("mul_valid", out_valid, 1'b1);
        chk("mul_code", out_alu_ctrl, 4'b1010);
        chk("mul_mc", out_multicycle, 1'b1);
`else
        @(negedge clock);
        chk("mul_valid", out_valid, 1'b1);
        chk("mul_ill", out_illegal, 1'b1);
        chk("mul_code", out_alu_ctrl, 4'b0010);
`endif
        step;
        drive(1'b1, 2'd2, 3'd5, 7'h01);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
`ifdef ALUCTL_MEXT_EN
        for (int i = 1; i < DIV_LAT; i++) begin
            @(negedge clock);
            chk("divu_wait", out_valid, 1'b0);
            step;
        end
        @(negedge clock);
        chk("divu_valid", out_valid, 1'b1);
        chk("divu_code", out_alu_ctrl, 4'b1101);
`else
        @(negedge clock);
        chk("divu_valid", out_valid, 1'b1);
        chk("divu_ill", out_illegal, 1'b1);
`endif
        step;

        // DIV flushed in cycle 3 with a request present
        drive(1'b1, 2'd2, 3'd4, 7'h01);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        step;
        step;
        flush = 1'b1;
        drive(1'b1, 2'd2, 3'd0, 7'h00);
        @(negedge clock);
        chk("flush_rdy", in_ready, 1'b0);
        step;
        flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        @(negedge clock);
        chk("flush_nval", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        step;
        @(negedge clock);
        chk("flush_dropped", out_valid, 1'b0);
        step;

        // reset while waiting on REM
        drive(1'b1, 2'd2, 3'd6, 7'h01);
        step;
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        @(negedge clock);
        chk("rstw_valid", out_valid, 1'b0);
        chk("rstw_ctrl", out_alu_ctrl, 4'h0);
        chk("rstw_ill", out_illegal, 1'b0);
        chk("rstw_mc", out_multicycle, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        step;

        // sweep the decode space with intermittent backpressure
        for (int op = 0; op < 4; op++) begin
            for (int s = 0; s < 4; s++) begin
                for (int f = 0; f < 8; f++) begin
                    drive(1'b1, 2'(op), 3'(f), f7s[s]);
                    acc = 1'b0;
                    guard = 0;
                    while (!acc && guard < 40) begin
                        @(negedge clock);
                        acc = (in_ready === 1'b1);
                        step;
                        guard++;
                        cyc++;
                        out_ready = (cyc % 3) != 0;
                    end
                    if (!acc) chk("sweep_accept_timeout", 32'd0, 32'd1);
                end
            end
        end
        drive(1'b0, 2'd0, 3'd0, 7'd0);
        out_ready = 1'b1;
        repeat (DIV_LAT + 4) step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
